// File: rtl/matmul_controller.sv
// matmul_controller: sequencer for an N x N matrix multiply C = A x B.
// Reads A/B element pairs through each memory's read port, multiply-accumulates
// them, writes each finished C element row-major through C's write port.
//
// Ports:
//   clk, rst        rising-edge clock, async active-low reset
//   start           request a multiply (sampled only in IDLE)
//   busy, done      busy in FETCH/MAC/WRITE; done pulses once per run
//   ovf             sticky: some C element did not fit in SIZE bits
//   a_read/a_addr   A read strobe/address (i*N+k), data returns next cycle on a_data
//   b_read/b_addr   B read strobe/address (k*N+j), data returns next cycle on b_data
//   c_write/c_addr/c_data  C write port (i*N+j, acc[SIZE-1:0])
module matmul_controller #(
  parameter int N     = 2,
  parameter int SIZE  = 8,
  parameter int ACC_W = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            ovf,
  output logic            a_read,
  output logic [5:0]      a_addr,
  input  logic [SIZE-1:0] a_data,
  output logic            b_read,
  output logic [5:0]      b_addr,
  input  logic [SIZE-1:0] b_data,
  output logic            c_write,
  output logic [5:0]      c_addr,
  output logic [SIZE-1:0] c_data
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [2:0] {IDLE, FETCH, MAC, WRITE, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       i, j, k;
  logic [CW-1:0]       ni, nj;
  logic                last_j, last_elem;
  logic [2*SIZE-1:0]   prod;
  logic [ACC_W-1:0]    acc, acc_sum;

  function automatic logic [5:0] addr(input logic [CW-1:0] r, input logic [CW-1:0] c);
    return 6'(r * N + c);
  endfunction

  // Full-width unsigned product, zero-extended into the accumulator.
  assign prod    = {{SIZE{1'b0}}, a_data} * {{SIZE{1'b0}}, b_data};
  assign acc_sum = acc + {{(ACC_W-2*SIZE){1'b0}}, prod};

  always_comb begin
    last_j    = (j == CW'(N-1));
    ni        = last_j ? i + 1'b1 : i;
    nj        = last_j ? '0 : j + 1'b1;
    last_elem = last_j && (i == CW'(N-1));
  end

  // Outputs are registered: each transition loads the values the next state presents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      a_read  <= 1'b0;
      b_read  <= 1'b0;
      c_write <= 1'b0;
      a_addr  <= '0;
      b_addr  <= '0;
      c_addr  <= '0;
      c_data  <= '0;
    end else begin
      a_read  <= 1'b0;
      b_read  <= 1'b0;
      c_write <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state  <= FETCH;
          i      <= '0;
          j      <= '0;
          k      <= '0;
          acc    <= '0;
          ovf    <= 1'b0;
          busy   <= 1'b1;
          a_read <= 1'b1;
          b_read <= 1'b1;
          a_addr <= '0;
          b_addr <= '0;
        end
        FETCH: state <= MAC;
        MAC: begin
          acc <= acc_sum;
          if (k == CW'(N-1)) begin
            state   <= WRITE;
            c_write <= 1'b1;
            c_addr  <= addr(i, j);
            c_data  <= acc_sum[SIZE-1:0];
          end else begin
            state  <= FETCH;
            k      <= k + 1'b1;
            a_read <= 1'b1;
            b_read <= 1'b1;
            a_addr <= addr(i, k + 1'b1);
            b_addr <= addr(k + 1'b1, j);
          end
        end
        WRITE: begin
          ovf <= ovf | ((acc >> SIZE) != '0);
          acc <= '0;
          k   <= '0;
          i   <= ni;
          j   <= nj;
          if (last_elem) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state  <= FETCH;
            a_read <= 1'b1;
            b_read <= 1'b1;
            a_addr <= addr(ni, '0);
            b_addr <= addr('0, nj);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_controller.sv
module tb_matmul_controller;
  localparam int N = 2, SIZE = 8, ACC_W = 18, NN = N * N;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic busy, done, ovf, a_read, b_read, c_write;
  logic [5:0] a_addr, b_addr, c_addr;
  logic [SIZE-1:0] a_data, b_data, c_data;

  int checks = 0, failures = 0;
  int mem_a [NN], mem_b [NN];
  logic [5:0] wa [$];
  int wd [$];
  int done_cnt = 0, strobe_viol = 0;
  int exp_c [NN];
  bit exp_ovf, exp_ovf0;

  always #5 clk = ~clk;

  matmul_controller #(.N(N), .SIZE(SIZE), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .ovf(ovf),
    .a_read(a_read), .a_addr(a_addr), .a_data(a_data),
    .b_read(b_read), .b_addr(b_addr), .b_data(b_data),
    .c_write(c_write), .c_addr(c_addr), .c_data(c_data));

  // Synchronous-read memories: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (a_read) a_data <= SIZE'(mem_a[a_addr % NN]);
    if (b_read) b_data <= SIZE'(mem_b[b_addr % NN]);
  end

  always @(negedge clk) begin
    if (c_write) begin
      wa.push_back(c_addr);
      wd.push_back(int'(c_data));
    end
    if (done) done_cnt++;
    if ((a_read || b_read || c_write) && !busy) strobe_viol++;
    if ((a_read || b_read) && c_write) strobe_viol++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain C = A x B with integer arithmetic.
  task automatic model();
    int s;
    exp_ovf = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        s = 0;
        for (int m = 0; m < N; m++) s += mem_a[r*N+m] * mem_b[m*N+c];
        exp_c[r*N+c] = s % (1 << SIZE);
        if (s >= (1 << SIZE)) exp_ovf = 1;
        if (r == 0 && c == 0) exp_ovf0 = (s >= (1 << SIZE));
      end
  endtask

  task automatic run_mm(input string tag, input bit hold);
    int cyc, lat, d0;
    model();
    wa.delete(); wd.delete();
    d0 = done_cnt;
    lat = -1;
    start = 1'b1;
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = (hold && cyc >= 5 && cyc < 8);
      if (cyc == 1) begin
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_ovf_clr"}, ovf, 0);
      end
      if (cyc == 6) chk({tag, "_ovf_first"}, ovf, exp_ovf0);
      if (done) begin lat = cyc - 1; break; end
    end
    start = 1'b0;
    chk({tag, "_latency"}, lat, NN * (2*N + 1));
    chk({tag, "_nwrites"}, wd.size(), NN);
    for (int e = 0; e < NN && e < wd.size(); e++) begin
      chk({tag, "_caddr"}, wa[e], e);
      chk({tag, "_cdata"}, wd[e], exp_c[e]);
    end
    chk({tag, "_ovf"}, ovf, exp_ovf);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
    repeat (3) @(negedge clk);
    chk({tag, "_ndone"}, done_cnt - d0, 1);
    chk({tag, "_no_restart"}, busy, 0);
    chk({tag, "_ovf_hold"}, ovf, exp_ovf);
  endtask

  initial begin
    #1;
    chk("rst_outs", {busy, done, ovf, a_read, b_read, c_write, a_addr, b_addr, c_addr, c_data}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    mem_a = '{1, 2, 3, 4}; mem_b = '{5, 6, 7, 8};
    run_mm("basic", 0);
    mem_a = '{200, 200, 200, 200}; mem_b = '{200, 200, 200, 200};
    run_mm("ovf", 0);
    mem_a = '{1, 2, 3, 4}; mem_b = '{5, 6, 7, 8};
    run_mm("ovf_clear", 0);
    mem_a = '{1, 0, 0, 1}; mem_b = '{0, 85, 1, 170};
    run_mm("ident", 0);
    mem_a = '{9, 8, 7, 6}; mem_b = '{5, 4, 3, 2};
    run_mm("hold_start", 1);

    // Reset asserted during MAC of element (0,1).
    model();
    wa.delete(); wd.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_outs", {busy, done, ovf, a_read, b_read, c_write, a_addr, b_addr, c_addr, c_data}, 0);
    repeat (4) @(negedge clk);
    chk("midrst_nwrites", wd.size(), 1);
    chk("midrst_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    run_mm("after_rst", 0);

    for (int t = 0; t < 6; t++) begin
      for (int e = 0; e < NN; e++) begin
        mem_a[e] = (t < 3) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255));
        mem_b[e] = (t < 3) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255));
      end
      run_mm($sformatf("rand%0d", t), 0);
    end

    chk("strobe_rules", strobe_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
